// File: rtl/comms_core_arbiter_if.sv
// Bundled requester, response and core-port signals of comms_core_arbiter.
// slave = the arbiter side, master = requesters plus core (environment) side.
interface comms_core_arbiter_if #(
  parameter int INSTRUCTION_WIDTH = 8,
  parameter int ADDRESS_WIDTH     = 24,
  parameter int VALUE_WIDTH       = 32
);
  logic [1:0]                   req_valid;
  logic [1:0]                   req_ready;
  logic [2*INSTRUCTION_WIDTH-1:0] req_instruction;
  logic [2*ADDRESS_WIDTH-1:0]   req_address;
  logic [2*VALUE_WIDTH-1:0]     req_value;

  logic [1:0]                   rsp_valid;
  logic [VALUE_WIDTH-1:0]       rsp_value;
  logic                         rsp_error;
  logic                         grant_id;

  logic                         core_valid;
  logic                         core_ready;
  logic [INSTRUCTION_WIDTH-1:0] core_instruction;
  logic [ADDRESS_WIDTH-1:0]     core_address;
  logic [VALUE_WIDTH-1:0]       core_value;
  logic                         core_rdata_valid;
  logic [VALUE_WIDTH-1:0]       core_rdata;

  modport slave (
    input  req_valid, req_instruction, req_address, req_value,
    output req_ready,
    output rsp_valid, rsp_value, rsp_error, grant_id,
    output core_valid, core_instruction, core_address, core_value,
    input  core_ready, core_rdata_valid, core_rdata
  );

  modport master (
    output req_valid, req_instruction, req_address, req_value,
    input  req_ready,
    input  rsp_valid, rsp_value, rsp_error, grant_id,
    input  core_valid, core_instruction, core_address, core_value,
    output core_ready, core_rdata_valid, core_rdata
  );
endinterface

// File: rtl/comms_core_arbiter.sv
// Round-robin arbiter passing one command at a time from two requesters to the core port.
// Define TITAN_ARB_TIMEOUT_EN to build a watchdog that abandons commands after TIMEOUT_CYCLES.
module comms_core_arbiter #(
  parameter int INSTRUCTION_WIDTH = 8,
  parameter int ADDRESS_WIDTH     = 24,
  parameter int VALUE_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input logic                 clk,
  input logic                 rst_n,
  comms_core_arbiter_if.slave bus
);
  // state   | meaning
  // IDLE    | arbitrate; winner's command accepted this cycle
  // ISSUE   | core_valid held with latched fields until core_ready
  // WAIT_RD | read accepted by core, waiting for core_rdata_valid
  // RESPOND | one-cycle rsp_valid to the granted requester

  localparam int IW = INSTRUCTION_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam int VW = VALUE_WIDTH;

  localparam logic [IW-1:0] OP_WRITE = IW'(1);
  localparam logic [IW-1:0] OP_READ  = IW'(2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic          last_grant_q;
  logic          grant_q;
  logic          win;
  logic          accept;
  logic          legal_op;
  logic          time_out;
  logic          abandon;
  logic [IW-1:0] win_instr;
  logic [AW-1:0] win_addr;
  logic [VW-1:0] win_value;
  logic [IW-1:0] instr_q;
  logic [AW-1:0] addr_q;
  logic [VW-1:0] value_q;
  logic [VW-1:0] rsp_data_q;
  logic          rsp_err_q;

  // A tie goes to the requester that did not own the port last time.
  always_comb begin
    win = 1'b0;
    if (&bus.req_valid) win = ~last_grant_q;
    else                win = bus.req_valid[1];
  end

  // Gated by rst_n so req_ready reads 0 while reset is held.
  assign accept    = rst_n && (state_q == IDLE) && (|bus.req_valid);
  assign win_instr = win ? bus.req_instruction[2*IW-1:IW] : bus.req_instruction[IW-1:0];
  assign win_addr  = win ? bus.req_address[2*AW-1:AW]     : bus.req_address[AW-1:0];
  assign win_value = win ? bus.req_value[2*VW-1:VW]       : bus.req_value[VW-1:0];
  assign legal_op  = (win_instr == OP_WRITE) || (win_instr == OP_READ);

`ifdef TITAN_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      timer_q <= '0;
    else if (state_q == ISSUE || state_q == WAIT_RD) timer_q <= timer_q + 1'b1;
    else                                             timer_q <= '0;
  end

  // Fires in the TIMEOUT_CYCLES-th cycle spent in ISSUE/WAIT_RD.
  assign time_out = (state_q == ISSUE || state_q == WAIT_RD) &&
                    (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign time_out       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    abandon = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = legal_op ? ISSUE : RESPOND;
      end
      ISSUE: begin
        if (bus.core_ready) begin
          state_d = (instr_q == OP_READ) ? WAIT_RD : RESPOND;
        end else if (time_out) begin
          state_d = RESPOND;
          abandon = 1'b1;
        end
      end
      WAIT_RD: begin
        if (bus.core_rdata_valid) begin
          state_d = RESPOND;
        end else if (time_out) begin
          state_d = RESPOND;
          abandon = 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      instr_q      <= '0;
      addr_q       <= '0;
      value_q      <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        grant_q    <= win;
        instr_q    <= win_instr;
        addr_q     <= win_addr;
        value_q    <= win_value;
        rsp_data_q <= '0;
        rsp_err_q  <= ~legal_op;
      end
      if (state_q == WAIT_RD && bus.core_rdata_valid) rsp_data_q <= bus.core_rdata;
      if (abandon)                                    rsp_err_q  <= 1'b1;
      if (state_q == RESPOND)                         last_grant_q <= grant_q;
    end
  end

  always_comb begin
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.rsp_value = '0;
    bus.rsp_error = 1'b0;
    if (accept) bus.req_ready[win] = 1'b1;
    if (state_q == RESPOND) begin
      bus.rsp_valid[grant_q] = 1'b1;
      bus.rsp_value          = rsp_data_q;
      bus.rsp_error          = rsp_err_q;
    end
  end

  assign bus.grant_id         = grant_q;
  assign bus.core_valid       = (state_q == ISSUE);
  assign bus.core_instruction = instr_q;
  assign bus.core_address     = addr_q;
  assign bus.core_value       = value_q;
endmodule

// File: tb/tb_comms_core_arbiter.sv
// Self-checking bench for comms_core_arbiter: vector table, random commands vs. a latency model,
// and hand sequences for contention and reset during a read.
module tb_comms_core_arbiter;
  localparam int IW = 8;
  localparam int AW = 24;
  localparam int VW = 32;
  localparam int TO = 8;
  localparam logic [IW-1:0] OP_WR = 8'h01;
  localparam logic [IW-1:0] OP_RD = 8'h02;
`ifdef TITAN_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comms_core_arbiter_if #(.INSTRUCTION_WIDTH(IW), .ADDRESS_WIDTH(AW), .VALUE_WIDTH(VW)) bus ();

  comms_core_arbiter #(
    .INSTRUCTION_WIDTH(IW), .ADDRESS_WIDTH(AW), .VALUE_WIDTH(VW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]          vmask;
    logic [1:0][IW-1:0]  ins;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][VW-1:0]  val;
    int                  n;        // cycles core_ready stays low in ISSUE
    int                  m;        // cycles core_rdata_valid stays low in WAIT_RD
    logic [VW-1:0]       rd;
    int                  exp_win;
    int                  exp_cyc;  // response cycle, accept cycle = 0
    logic [VW-1:0]       exp_val;
    logic                exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit last_grant_m = 1'b1;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [1:0] vm, logic [IW-1:0] i0, logic [IW-1:0] i1,
                              logic [AW-1:0] a0, logic [AW-1:0] a1,
                              logic [VW-1:0] v0, logic [VW-1:0] v1, int n, int m,
                              logic [VW-1:0] rd, int w, int c, logic [VW-1:0] ev, logic ee);
    vec_t v;
    v.vmask = vm; v.ins[0] = i0; v.ins[1] = i1; v.addr[0] = a0; v.addr[1] = a1;
    v.val[0] = v0; v.val[1] = v1; v.n = n; v.m = m; v.rd = rd;
    v.exp_win = w; v.exp_cyc = c; v.exp_val = ev; v.exp_err = ee;
    return v;
  endfunction

  // Response timing from the handshake rules: a command completes in the cycle of its
  // last core handshake, answers the cycle after, or is cut off by the watchdog.
  function automatic void model_rsp(input logic [IW-1:0] op, input int n, input int m,
                                    input logic [VW-1:0] rd, output int cyc,
                                    output logic [VW-1:0] val, output logic err);
    int progress;
    if (op != OP_WR && op != OP_RD) begin
      cyc = 1; val = '0; err = 1'b1;
      return;
    end
    progress = (op == OP_WR) ? n + 1 : n + 2 + m;
    if (TO_EN && progress > TO) begin
      cyc = TO + 1; val = '0; err = 1'b1;
    end else begin
      cyc = progress + 1; val = (op == OP_RD) ? rd : '0; err = 1'b0;
    end
  endfunction

  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_instruction = '0; bus.req_address = '0; bus.req_value = '0;
    bus.core_ready = 1'b0; bus.core_rdata_valid = 1'b0; bus.core_rdata = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ctrl"}, {bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.grant_id, bus.core_valid}, 0);
    chk({tag, ".rsp_value"}, bus.rsp_value, 0);
    chk({tag, ".core_ia"}, {bus.core_instruction, bus.core_address}, 0);
    chk({tag, ".core_value"}, bus.core_value, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_grant_m = 1'b1;
  endtask

  task automatic run_cmd(input string tag, input vec_t v);
    int issue_cnt = 0, wait_cnt = 0, rsp_cnt = 0;
    bit waiting = 0, core_seen = 0, done = 0;
    logic [IW-1:0] wi;
    bit legal;
    wi = v.ins[v.exp_win];
    legal = (wi == OP_WR) || (wi == OP_RD);
    @(negedge clk);
    bus.req_valid = v.vmask;
    bus.req_instruction = v.ins;
    bus.req_address = v.addr;
    bus.req_value = v.val;
    for (int c = 0; c <= 60 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c == 1) begin
          bus.req_valid[v.exp_win] = 1'b0;
          bus.req_instruction[v.exp_win*IW +: IW] = ~wi;
          bus.req_address[v.exp_win*AW +: AW] = AW'($urandom);
          bus.req_value[v.exp_win*VW +: VW] = $urandom;
        end
        if (rsp_cnt > 0) begin
          bus.req_valid = '0;
          done = 1;
        end
      end
      if (waiting) begin
        bus.core_rdata_valid = (wait_cnt >= v.m);
        bus.core_rdata = v.rd;
        wait_cnt++;
      end else begin
        bus.core_rdata_valid = 1'($urandom_range(0, 1));
        bus.core_rdata = $urandom;
      end
      if (bus.core_valid) begin
        if (!core_seen) begin
          chk({tag, ".core_instruction"}, bus.core_instruction, wi);
          chk({tag, ".core_address"}, bus.core_address, v.addr[v.exp_win]);
          chk({tag, ".core_value"}, bus.core_value, v.val[v.exp_win]);
          chk({tag, ".grant_id"}, bus.grant_id, v.exp_win);
        end
        core_seen = 1;
        bus.core_ready = (issue_cnt >= v.n);
        issue_cnt++;
        if (bus.core_ready && wi == OP_RD) waiting = 1;
      end else begin
        bus.core_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (c == 0) chk({tag, ".req_ready_accept"}, bus.req_ready, 2'b01 << v.exp_win);
      else        chk({tag, ".req_ready_busy"}, bus.req_ready, 0);
      if (done) begin
        chk({tag, ".rsp_one_cycle"}, bus.rsp_valid, 0);
        chk({tag, ".core_valid_after"}, bus.core_valid, 0);
      end else if (bus.rsp_valid != 2'b00) begin
        rsp_cnt++;
        chk({tag, ".rsp_cycle"}, c, v.exp_cyc);
        chk({tag, ".rsp_valid"}, bus.rsp_valid, 2'b01 << v.exp_win);
        chk({tag, ".rsp_value"}, bus.rsp_value, v.exp_val);
        chk({tag, ".rsp_error"}, bus.rsp_error, v.exp_err);
      end
    end
    chk({tag, ".completed_in_budget"}, done, 1);
    chk({tag, ".core_valid_seen"}, core_seen, legal);
    last_grant_m = (v.exp_win != 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    idle_inputs();
    vecs.push_back(mk(2'b01, OP_WR, 8'h00, 24'h000010, 24'h0, 32'hDEADBEEF, 32'h0,
                      0, 0, 32'h0, 0, 2, 32'h0, 1'b0));
    vecs.push_back(mk(2'b10, 8'h00, OP_RD, 24'h0, 24'h000004, 32'h0, 32'h0,
                      3, 1, 32'h12345678, 1, 7, 32'h12345678, 1'b0));
    vecs.push_back(mk(2'b01, 8'h04, 8'h00, 24'h000020, 24'h0, 32'h11111111, 32'h0,
                      0, 0, 32'h0, 0, 1, 32'h0, 1'b1));
    vecs.push_back(mk(2'b11, OP_WR, OP_RD, 24'h000100, 24'h000200, 32'h22222222, 32'h33333333,
                      0, 0, 32'hA5A5A5A5, 1, 3, 32'hA5A5A5A5, 1'b0));
    vecs.push_back(mk(2'b11, OP_WR, OP_RD, 24'hABCDEF, 24'h000300, 32'h44444444, 32'h0,
                      7, 0, 32'h0, 0, 9, 32'h0, 1'b0));
    vecs.push_back(mk(2'b10, 8'h00, 8'h00, 24'h0, 24'h000400, 32'h0, 32'h55555555,
                      0, 0, 32'h0, 1, 1, 32'h0, 1'b1));
    vecs.push_back(mk(2'b11, OP_RD, 8'hFF, 24'h000500, 24'h000600, 32'h0, 32'h0,
                      1, 2, 32'h00000001, 0, 6, 32'h00000001, 1'b0));
`ifdef TITAN_ARB_TIMEOUT_EN
    vecs.push_back(mk(2'b01, OP_RD, 8'h00, 24'h000700, 24'h0, 32'h0, 32'h0,
                      255, 0, 32'hFFFFFFFF, 0, 9, 32'h0, 1'b1));
    vecs.push_back(mk(2'b10, 8'h00, OP_WR, 24'h0, 24'h000800, 32'h0, 32'h66666666,
                      0, 0, 32'h0, 1, 2, 32'h0, 1'b0));
`endif

    do_reset();
    for (int i = 0; i < vecs.size(); i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    for (int k = 0; k < 40; k++) begin
      vec_t v;
      v.vmask = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        case ($urandom_range(0, 4))
          0:       v.ins[r] = IW'($urandom);
          1, 2:    v.ins[r] = OP_WR;
          default: v.ins[r] = OP_RD;
        endcase
        v.addr[r] = AW'($urandom);
        v.val[r] = $urandom;
      end
      v.n = $urandom_range(0, 3);
      v.m = $urandom_range(0, 3);
      v.rd = $urandom;
      v.exp_win = (v.vmask == 2'b11) ? (last_grant_m ? 0 : 1) : (v.vmask[1] ? 1 : 0);
      model_rsp(v.ins[v.exp_win], v.n, v.m, v.rd, v.exp_cyc, v.exp_val, v.exp_err);
      run_cmd($sformatf("rnd%0d", k), v);
    end

    // Contention: both requesters hold write commands continuously, four each.
    begin
      int acc[2] = '{0, 0};
      int order[$];
      int last_c = 0;
      do_reset();
      bus.req_instruction = {OP_WR, OP_WR};
      bus.req_address = {24'h000B00, 24'h000A00};
      bus.req_value = {32'hBBBBBBBB, 32'hAAAAAAAA};
      bus.core_ready = 1'b1;
      for (int c = 0; c < 80 && order.size() < 8; c++) begin
        @(negedge clk);
        bus.req_valid = {acc[1] < 4, acc[0] < 4};
        #1;
        if (bus.req_ready != 2'b00) begin
          int g;
          chk("cont.ready_onehot", $countones(bus.req_ready), 1);
          g = bus.req_ready[1] ? 1 : 0;
          order.push_back(g);
          acc[g]++;
          if (order.size() > 1) chk("cont.accept_spacing", c - last_c, 3);
          last_c = c;
        end
      end
      chk("cont.accepted_total", order.size(), 8);
      chk("cont.accepts_req0", acc[0], 4);
      chk("cont.accepts_req1", acc[1], 4);
      for (int k = 0; k < order.size(); k++) chk($sformatf("cont.order%0d", k), order[k], k % 2);
      @(negedge clk);
      bus.req_valid = '0;
      repeat (4) @(negedge clk);
    end

    // Reset while a read waits for data: everything clears and no response follows.
    begin
      int stray_rsp = 0;
      int stray_core = 0;
      do_reset();
      @(negedge clk);
      bus.req_valid = 2'b01;
      bus.req_instruction = {8'h00, OP_RD};
      bus.req_address = {24'h0, 24'h00C0DE};
      bus.req_value = {32'h0, 32'h77777777};
      bus.core_ready = 1'b1;
      #1;
      chk("midrst.accept", bus.req_ready, 2'b01);
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      #1;
      chk("midrst.in_wait_rd", {bus.core_valid, bus.rsp_valid}, 0);
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      bus.core_rdata_valid = 1'b1;
      bus.core_rdata = 32'hCAFEF00D;
      repeat (6) begin
        @(negedge clk);
        #1;
        if (bus.rsp_valid != 2'b00) stray_rsp++;
        if (bus.core_valid) stray_core++;
      end
      chk("midrst.no_rsp", stray_rsp, 0);
      chk("midrst.no_core_valid", stray_core, 0);
      idle_inputs();
      last_grant_m = 1'b1;
      run_cmd("post_rst", mk(2'b10, 8'h00, OP_WR, 24'h0, 24'h000900, 32'h0, 32'h99999999,
                             0, 0, 32'h0, 1, 2, 32'h0, 1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/comms_core_arbiter.md
# comms_core_arbiter

Arbitrates access to the core register/memory port between two command requesters: requester 0 is the SPI `instruction_handler` and requester 1 is a second host port. It accepts one decoded command (instruction, address, value) at a time using round-robin, sequences it onto the core with a valid/ready handshake, and waits for read data when needed. It returns a one-cycle response, carrying the read value or an error flag, to the requester that issued the command.

## Interface
- `INSTRUCTION_WIDTH`, 8: opcode width; codes follow TitanComms (WRITE=8'h01, READ=8'h02).
- `ADDRESS_WIDTH`, 24: core address width.
- `VALUE_WIDTH`, 32: data width.
- `TIMEOUT_CYCLES`, 255: watchdog limit; used only when `TITAN_ARB_TIMEOUT_EN` is defined.

- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 2: per-requester command valid.
- `req_ready` output 2: per-requester accept.
- `req_instruction` input 2*INSTRUCTION_WIDTH: packed; requester i uses slice i.
- `req_address` input 2*ADDRESS_WIDTH: packed per requester.
- `req_value` input 2*VALUE_WIDTH: packed per requester.
- `rsp_valid` output 2: one-cycle response strobe to the issuing requester.
- `rsp_value` output VALUE_WIDTH: read data; 0 for writes and errors.
- `rsp_error` output 1: qualified by `rsp_valid`; set for an illegal opcode or a timeout.
- `grant_id` output 1: requester currently owning the core port.
- `core_valid` output 1: command to core valid.
- `core_ready` input 1: core accepts command.
- `core_instruction`, `core_address`, `core_value` output: latched command fields.
- `core_rdata_valid` input 1: read data strobe from core.
- `core_rdata` input VALUE_WIDTH: read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, RESPOND.
- **IDLE**
  - Arbitration when only one `req_valid` is high: that requester wins.
  - Arbitration when both are high: the requester that is not `last_grant` wins.
  - `req_ready[g]` is high combinationally for the winner only. The command transfers in that cycle.
  - The winner's fields are latched, and `grant_id` is set to g.
  - If the opcode is WRITE or READ, go to ISSUE. Otherwise, go to RESPOND with the error flag set, and nothing is sent to the core.
- **ISSUE**
  - `core_valid`=1 with the latched fields, held stable until `core_ready`.
  - On `core_ready`, a WRITE goes to RESPOND with value 0 and no error.
  - On `core_ready`, a READ goes to WAIT_RD.
- **WAIT_RD**
  - On `core_rdata_valid`, capture `core_rdata` and go to RESPOND.
- **RESPOND**
  - `rsp_valid[grant_id]`=1 for exactly one cycle, with `rsp_value` and `rsp_error` valid in the same cycle.
  - `last_grant` is updated to `grant_id`, then the FSM returns to IDLE.
- Requesters must hold their fields stable while `req_valid` is high and `req_ready` is low. After acceptance, the fields may change freely.
- `core_rdata_valid` outside WAIT_RD is ignored.
- `req_ready` is 0 in every state except IDLE, so at most one command is outstanding.
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - Latched fields are 0.
  - `last_grant`=1, so requester 0 wins the first tie.
- Reset asserted mid-transaction: the FSM drops immediately to IDLE, `core_valid` drops, and no response is issued for the abandoned command.

## Timing
- Cycle numbering: cycle 0 is the accept cycle.
- Write with `core_ready` already high: `core_valid` in cycle 1, `rsp_valid` in cycle 2, IDLE in cycle 3. The next accept is possible in cycle 3 at the earliest.
- Read with `core_ready` already high: core handshake in cycle 1, earliest `core_rdata_valid` in cycle 2, `rsp_valid` in cycle 3.
- Illegal opcode: `rsp_valid` with `rsp_error`=1 in cycle 1.
- Each stall cycle of `core_ready` or `core_rdata_valid` adds exactly one cycle of latency.
- Fairness: when both requesters hold `req_valid` continuously, grants alternate 0,1,0,1.

## Configuration
- Macro: `TITAN_ARB_TIMEOUT_EN`.
- **When defined**
  - A cycle counter of width `$clog2(TIMEOUT_CYCLES+1)` is cleared on entry to ISSUE and counts in ISSUE and WAIT_RD.
  - When it reaches `TIMEOUT_CYCLES` without progress, the FSM goes to RESPOND with `rsp_error`=1 and `rsp_value`=0. `core_valid` deasserts and the command is abandoned.
  - A handshake landing in the same cycle as the timeout takes priority over the timeout.
- **When undefined**
  - No counter is built, and the FSM waits indefinitely.
  - `rsp_error` is raised only for an illegal opcode.

## Test plan
- Single write, requester 0: instruction 8'h01, address 24'h000010, value 32'hDEADBEEF, with `core_ready` held 1. Required: core fields match in cycle 1, `rsp_valid`=2'b01 in cycle 2, `rsp_value`=0, `rsp_error`=0.
- Read, requester 1: instruction 8'h02, address 24'h000004; `core_ready` stalls 3 cycles, then `core_rdata`=32'h12345678 arrives 2 cycles later. Required: `rsp_valid`=2'b10 with `rsp_value`=32'h12345678 and no error.
- Contention: both requesters hold valid writes for 4 commands each. Required grant order from reset: 0,1,0,1,…; each `req_ready` pulses exactly once per accepted command.
- Illegal opcode 8'h04 from requester 0. Required: `core_valid` never asserts, `rsp_error`=1 in cycle 1, `rsp_value`=0.
- With `TITAN_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, and `core_ready` tied 0: a read receives `rsp_error`=1 exactly 8 cycles after entering ISSUE, and the FSM then accepts the next request. Assert `rst_n` low during WAIT_RD in a separate run: all outputs are 0 immediately and no `rsp_valid` follows.
